depth_engine_pipe: RTL and testbench

Parametrised successor to the single-pixel escape-time engine. It computes Mandelbrot or Julia escape depth for one pixel at a time, one iteration per clock, with no idle wait cycle between iterations. It uses valid/ready handshakes on input and output and carries a pixel tag through to the result. It sits between the pixel-coordinate generator and the depth FIFO/colour mapper, and N instances are replicated by the multi-engine wrapper.

---
 rtl/depth_engine_pipe.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_depth_engine_pipe.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/depth_engine_pipe.sv
// -----------------------------------------------------------------------------
// depth_engine_pipe
//   Escape-time engine for one pixel at a time (Mandelbrot or Julia). It runs
//   one iteration per clock with no idle cycle between iterations. A pixel is
//   accepted on an in_valid/in_ready handshake. Its tag is carried through to
//   the result, which is held on out_* until out_valid/out_ready complete.
//
//   Optional feature macro: PERIOD_CHECK_EN
//     When it is defined, a snapshot of z is taken whenever depth is a power
//     of two. A later exact repeat of that z ends the pixel early as interior.
//     The port list is the same in both builds.
//
// Ports
//   sysclk               clock, rising edge
//   reset_n              asynchronous active-low reset
//   max_iter             iteration limit, captured at accept
//   julia_mode           0 = Mandelbrot, 1 = Julia, captured at accept
//   julia_re/julia_im    Julia constant c, captured at accept
//   in_valid/in_ready    pixel request handshake
//   in_re/in_im/in_tag   pixel coordinate and opaque tag
//   out_valid/out_ready  result handshake
//   out_depth            escape depth
//   out_tag              tag of the pixel that the result belongs to
//   out_escaped          1 = escaped, 0 = limit reached or periodic exit
// -----------------------------------------------------------------------------
module depth_engine_pipe #(
    parameter int WORD_LENGTH = 32,
    parameter int FRAC        = 28,
    parameter int ITER_W      = 10,
    parameter int TAG_W       = 20
) (
    input  logic                          sysclk,
    input  logic                          reset_n,
    input  logic [ITER_W-1:0]             max_iter,
    input  logic                          julia_mode,
    input  logic signed [WORD_LENGTH-1:0] julia_re,
    input  logic signed [WORD_LENGTH-1:0] julia_im,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [WORD_LENGTH-1:0] in_re,
    input  logic signed [WORD_LENGTH-1:0] in_im,
    input  logic [TAG_W-1:0]              in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ITER_W-1:0]             out_depth,
    output logic [TAG_W-1:0]              out_tag,
    output logic                          out_escaped
);

    localparam int W  = WORD_LENGTH;
    localparam int PW = 2 * WORD_LENGTH;

    // |z|^2 escape threshold: 4.0 in the Q.(2*FRAC) product format
    localparam logic [PW:0] ESC_LIMIT = {{(PW-2){1'b0}}, 3'b100} << (2 * FRAC);
    localparam logic [ITER_W-1:0] ITER_ONE  = {{(ITER_W-1){1'b0}}, 1'b1};
    localparam logic [ITER_W-1:0] ITER_ZERO = {ITER_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic signed [W-1:0]  re_q, re_d, im_q, im_d;
    logic signed [W-1:0]  c_re_q, c_re_d, c_im_q, c_im_d;
    logic [ITER_W-1:0]    depth_q, depth_d, max_iter_q, max_iter_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [ITER_W-1:0]    out_depth_q, out_depth_d;
    logic [TAG_W-1:0]     out_tag_q, out_tag_d;
    logic                 out_escaped_q, out_escaped_d;

    logic signed [PW-1:0] re_ext_s, im_ext_s;
    logic signed [PW-1:0] re_sq_s, im_sq_s, re_im_s, diff_s;
    logic [PW:0]          mag_s;
    logic signed [W-1:0]  re_next_s, im_next_s;
    logic                 accept_s, escape_s, limit_s, period_hit_s, stop_s;
    logic                 unused_bits_s;

    // Iteration arithmetic: full-width squares, magnitude and the next z
    always_comb begin
        re_ext_s = {{W{re_q[W-1]}}, re_q};
        im_ext_s = {{W{im_q[W-1]}}, im_q};
        re_sq_s  = re_ext_s * re_ext_s;
        im_sq_s  = im_ext_s * im_ext_s;
        re_im_s  = re_ext_s * im_ext_s;
        // Squares are non-negative, so a zero-extended sum cannot overflow
        mag_s    = {1'b0, re_sq_s} + {1'b0, im_sq_s};
        diff_s   = re_sq_s - im_sq_s;
        // Taking the bit window is the same as >>> FRAC followed by truncation.
        // 2*re*im >>> FRAC is the same as re*im >>> (FRAC-1).
        re_next_s = diff_s[FRAC +: W] + c_re_q;
        im_next_s = re_im_s[(FRAC-1) +: W] + c_im_q;
        escape_s  = (mag_s > ESC_LIMIT);
        limit_s   = (depth_q == max_iter_q);
        accept_s  = in_valid && in_ready_q;
        unused_bits_s = ^{diff_s[FRAC-1:0], diff_s[PW-1:FRAC+W],
                          re_im_s[FRAC-2:0], re_im_s[PW-1:FRAC+W-1]};
    end

`ifdef PERIOD_CHECK_EN
    logic signed [W-1:0] snap_re_q, snap_re_d, snap_im_q, snap_im_d;
    logic                snap_valid_q, snap_valid_d;
    logic                depth_pow2_s;

    // Periodicity detector: compare against the snapshot, then reload it at power-of-two depths
    always_comb begin
        depth_pow2_s = (depth_q != ITER_ZERO) && ((depth_q & (depth_q - ITER_ONE)) == ITER_ZERO);
        period_hit_s = snap_valid_q && (re_q == snap_re_q) && (im_q == snap_im_q);
        snap_re_d    = snap_re_q;
        snap_im_d    = snap_im_q;
        snap_valid_d = snap_valid_q;
        if (state_q == IDLE) begin
            snap_valid_d = 1'b0;
        end else if ((state_q == ITER) && !escape_s && !limit_s && !period_hit_s && depth_pow2_s) begin
            snap_re_d    = re_q;
            snap_im_d    = im_q;
            snap_valid_d = 1'b1;
        end else begin
            snap_valid_d = snap_valid_q;
        end
    end

    // Snapshot registers
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            snap_re_q    <= {W{1'b0}};
            snap_im_q    <= {W{1'b0}};
            snap_valid_q <= 1'b0;
        end else begin
            snap_re_q    <= snap_re_d;
            snap_im_q    <= snap_im_d;
            snap_valid_q <= snap_valid_d;
        end
    end
`else
    // Interior pixels always run to max_iter when there is no snapshot logic
    always_comb begin
        period_hit_s = 1'b0;
    end
`endif

    // An iteration ends on escape, on the limit, or on a detected cycle
    always_comb begin
        stop_s = escape_s || limit_s || period_hit_s;
    end

    // State register
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) state_d = ITER;
                else          state_d = IDLE;
            end
            ITER: begin
                if (stop_s) state_d = DONE;
                else        state_d = ITER;
            end
            DONE: begin
                if (out_valid_q && out_ready) state_d = IDLE;
                else                          state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic. out_valid comes up one cycle after DONE is entered and
    // drops on the edge that completes the handshake.
    always_comb begin
        in_ready_d    = (state_d == IDLE);
        out_valid_d   = (state_q == DONE) && !(out_valid_q && out_ready);
        out_depth_d   = out_depth_q;
        out_tag_d     = out_tag_q;
        out_escaped_d = out_escaped_q;
        if ((state_q == ITER) && stop_s) begin
            out_tag_d = tag_q;
            if (escape_s) begin
                out_depth_d   = depth_q;
                out_escaped_d = 1'b1;
            end else begin
                out_depth_d   = max_iter_q;
                out_escaped_d = 1'b0;
            end
        end else begin
            out_tag_d = out_tag_q;
        end
    end

    // Pixel context: capture at accept, advance z and depth while iterating
    always_comb begin
        re_d       = re_q;
        im_d       = im_q;
        c_re_d     = c_re_q;
        c_im_d     = c_im_q;
        depth_d    = depth_q;
        max_iter_d = max_iter_q;
        tag_d      = tag_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    tag_d      = in_tag;
                    max_iter_d = max_iter;
                    depth_d    = ITER_ZERO;
                    if (julia_mode) begin
                        re_d   = in_re;
                        im_d   = in_im;
                        c_re_d = julia_re;
                        c_im_d = julia_im;
                    end else begin
                        re_d   = {W{1'b0}};
                        im_d   = {W{1'b0}};
                        c_re_d = in_re;
                        c_im_d = in_im;
                    end
                end else begin
                    tag_d = tag_q;
                end
            end
            ITER: begin
                if (!stop_s) begin
                    re_d    = re_next_s;
                    im_d    = im_next_s;
                    depth_d = depth_q + ITER_ONE;
                end else begin
                    depth_d = depth_q;
                end
            end
            DONE:    depth_d = depth_q;
            default: depth_d = depth_q;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            re_q          <= {W{1'b0}};
            im_q          <= {W{1'b0}};
            c_re_q        <= {W{1'b0}};
            c_im_q        <= {W{1'b0}};
            depth_q       <= ITER_ZERO;
            max_iter_q    <= ITER_ZERO;
            tag_q         <= {TAG_W{1'b0}};
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_depth_q   <= ITER_ZERO;
            out_tag_q     <= {TAG_W{1'b0}};
            out_escaped_q <= 1'b0;
        end else begin
            re_q          <= re_d;
            im_q          <= im_d;
            c_re_q        <= c_re_d;
            c_im_q        <= c_im_d;
            depth_q       <= depth_d;
            max_iter_q    <= max_iter_d;
            tag_q         <= tag_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_depth_q   <= out_depth_d;
            out_tag_q     <= out_tag_d;
            out_escaped_q <= out_escaped_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_depth   = out_depth_q;
    assign out_tag     = out_tag_q;
    assign out_escaped = out_escaped_q;

endmodule

// File: tb/tb_depth_engine_pipe.sv
// -----------------------------------------------------------------------------
// tb_depth_engine_pipe
//   Scoreboard bench for depth_engine_pipe. The driver pushes the expected
//   result of each pixel at accept. The monitor pops and compares on every
//   output handshake. Latency is measured from the accept edge to the rise of
//   out_valid.
// -----------------------------------------------------------------------------
module tb_depth_engine_pipe;

    logic               sysclk;
    logic               reset_n;
    logic [9:0]         max_iter;
    logic               julia_mode;
    logic signed [31:0] julia_re, julia_im;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] in_re, in_im;
    logic [19:0]        in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [9:0]         out_depth;
    logic [19:0]        out_tag;
    logic               out_escaped;

    depth_engine_pipe dut (
        .sysclk      (sysclk),
        .reset_n     (reset_n),
        .max_iter    (max_iter),
        .julia_mode  (julia_mode),
        .julia_re    (julia_re),
        .julia_im    (julia_im),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_re       (in_re),
        .in_im       (in_im),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_depth   (out_depth),
        .out_tag     (out_tag),
        .out_escaped (out_escaped)
    );

    typedef struct {
        logic [9:0]  d;
        logic        e;
        logic [19:0] tag;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   rise_cyc = 0;
    logic prev_valid = 1'b0;
    logic rand_bp    = 1'b0;

    localparam logic signed [31:0] ONE  = 32'sh1000_0000;
    localparam logic signed [31:0] TWO  = 32'sh2000_0000;
    localparam logic signed [31:0] HALF = 32'sh0800_0000;

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference escape-time model. lat = ITER cycles + 1.
    function automatic void ref_model(input logic signed [31:0] zr0, input logic signed [31:0] zi0,
                                      input logic signed [31:0] cr, input logic signed [31:0] ci,
                                      input logic [9:0] mx, output logic [9:0] d,
                                      output logic e, output int lat);
        logic signed [31:0] zr, zi, sr, si;
        logic               sv;
        longint             rr, ii, ri;
        logic [64:0]        mag;
        zr = zr0; zi = zi0; sr = 32'sd0; si = 32'sd0; sv = 1'b0;
        d = 10'd0; e = 1'b0; lat = 0;
        for (int n = 0; n <= 1023; n++) begin
            rr  = longint'(zr) * longint'(zr);
            ii  = longint'(zi) * longint'(zi);
            ri  = longint'(zr) * longint'(zi);
            mag = {1'b0, rr} + {1'b0, ii};
            lat = n + 2;
            if (mag > (65'd1 << 58)) begin d = 10'(n); e = 1'b1; break; end
            if (10'(n) == mx) begin d = mx; e = 1'b0; break; end
`ifdef PERIOD_CHECK_EN
            if (sv && zr == sr && zi == si) begin d = mx; e = 1'b0; break; end
            if (n > 0 && (n & (n - 1)) == 0) begin sr = zr; si = zi; sv = 1'b1; end
`endif
            zr = 32'((rr - ii) >>> 28) + cr;
            zi = 32'(ri >>> 27) + ci;
        end
    endfunction

    task automatic send(input logic signed [31:0] re, input logic signed [31:0] im,
                        input logic jm, input logic signed [31:0] jr, input logic signed [31:0] ji,
                        input logic [9:0] mx, input logic [19:0] tag,
                        input logic [9:0] ed, input logic ee, input int elat);
        int t;
        exp_t x;
        @(negedge sysclk);
        in_re = re; in_im = im; julia_mode = jm; julia_re = jr; julia_im = ji;
        max_iter = mx; in_tag = tag; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 3000) begin @(negedge sysclk); t++; end
        if (!in_ready) check_value("in_ready_wait", {63'd0, in_ready}, 64'd1);
        @(posedge sysclk);
        #1;
        x.d = ed; x.e = ee; x.tag = tag; x.lat = elat; x.acc = cyc;
        sb.push_back(x);
        in_valid   = 1'b0;
        in_re      = $urandom;
        in_im      = $urandom;
        max_iter   = 10'($urandom);
        julia_mode = ~jm;
        julia_re   = $urandom;
        julia_im   = $urandom;
        in_tag     = 20'($urandom);
    endtask

    task automatic send_rand(input logic [19:0] tag);
        logic signed [31:0] re, im, jr, ji;
        logic               jm;
        logic [9:0]         mx, d;
        logic               e;
        int                 lat;
        re = $signed($urandom_range(0, 32'h4000_0000)) - TWO;
        im = $signed($urandom_range(0, 32'h4000_0000)) - TWO;
        jr = $signed($urandom_range(0, 32'h2000_0000)) - ONE;
        ji = $signed($urandom_range(0, 32'h2000_0000)) - ONE;
        jm = 1'($urandom_range(0, 1));
        mx = 10'($urandom_range(1, 40));
        if (jm) ref_model(re, im, jr, ji, mx, d, e, lat);
        else    ref_model(32'sd0, 32'sd0, re, im, mx, d, e, lat);
        send(re, im, jm, jr, ji, mx, tag, d, e, lat);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || !in_ready || in_valid) && t < 5000) begin
            @(negedge sysclk); t++;
        end
        check_value("drain", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: measure out_valid rise and score each output handshake
    initial begin
        exp_t x;
        forever begin
            @(negedge sysclk);
            if (!reset_n) begin
                prev_valid = 1'b0;
            end else begin
                if (out_valid && !prev_valid) rise_cyc = cyc;
                prev_valid = out_valid;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check_value("spurious_out", {63'd0, out_valid}, 64'd0);
                    end else begin
                        x = sb.pop_front();
                        check_value("depth", 64'(out_depth), 64'(x.d));
                        check_value("escaped", {63'd0, out_escaped}, {63'd0, x.e});
                        check_value("tag", 64'(out_tag), 64'(x.tag));
                        check_value("latency", 64'(rise_cyc - x.acc), 64'(x.lat));
                        check_value("ready_excl", {63'd0, in_ready}, 64'd0);
                    end
                end
            end
        end
    end

    // Random backpressure generator, active only when rand_bp is set
    initial begin
        forever begin
            @(posedge sysclk);
            #2;
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int t;
        int stale;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_re = 32'sd0; in_im = 32'sd0; in_tag = 20'd0; max_iter = 10'd0;
        julia_mode = 1'b0; julia_re = 32'sd0; julia_im = 32'sd0;
        repeat (3) @(posedge sysclk);
        #2;
        check_value("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check_value("rst_outs", {33'd0, out_valid, out_escaped, out_depth, out_tag}, 64'd0);
        @(negedge sysclk);
        reset_n = 1'b1;

        // Basic Mandelbrot / Julia points
`ifdef PERIOD_CHECK_EN
        send(32'sd0, 32'sd0, 1'b0, 32'sd0, 32'sd0, 10'd20, 20'h00001, 10'd20, 1'b0, 4);
        send(ONE, 32'sd0, 1'b0, 32'sd0, 32'sd0, 10'd100, 20'h00002, 10'd3, 1'b1, 5);
        send(-TWO, 32'sd0, 1'b0, 32'sd0, 32'sd0, 10'd100, 20'h00003, 10'd100, 1'b0, 5);
`else
        send(32'sd0, 32'sd0, 1'b0, 32'sd0, 32'sd0, 10'd20, 20'h00001, 10'd20, 1'b0, 22);
        send(ONE, 32'sd0, 1'b0, 32'sd0, 32'sd0, 10'd100, 20'h00002, 10'd3, 1'b1, 5);
        send(-TWO, 32'sd0, 1'b0, 32'sd0, 32'sd0, 10'd100, 20'h00003, 10'd100, 1'b0, 102);
`endif
        send(TWO, TWO, 1'b1, 32'sd0, 32'sd0, 10'd50, 20'h12345, 10'd0, 1'b1, 2);
        send(HALF, 32'sd0, 1'b0, 32'sd0, 32'sd0, 10'd0, 20'h00abc, 10'd0, 1'b0, 2);
        send(32'sh3000_0000, 32'sd0, 1'b1, 32'sd0, 32'sd0, 10'd0, 20'h00abd, 10'd0, 1'b1, 2);
        send(32'sd0, 32'sd0, 1'b1, ONE, 32'sd0, 10'd100, 20'h00abe, 10'd3, 1'b1, 5);
`ifdef PERIOD_CHECK_EN
        send(-ONE, 32'sd0, 1'b0, 32'sd0, 32'sd0, 10'd1000, 20'h00006, 10'd1000, 1'b0, 6);
        send(32'sd0, 32'sd0, 1'b0, 32'sd0, 32'sd0, 10'd1000, 20'h00007, 10'd1000, 1'b0, 4);
`else
        send(-ONE, 32'sd0, 1'b0, 32'sd0, 32'sd0, 10'd1000, 20'h00006, 10'd1000, 1'b0, 1002);
        send(32'sd0, 32'sd0, 1'b0, 32'sd0, 32'sd0, 10'd1000, 20'h00007, 10'd1000, 1'b0, 1002);
`endif
        drain();

        // Backpressure: hold the result, then release with a second pixel waiting
        @(posedge sysclk); #2; out_ready = 1'b0;
        send(ONE, 32'sd0, 1'b0, 32'sd0, 32'sd0, 10'd100, 20'haaaaa, 10'd3, 1'b1, 5);
        t = 0;
        while (!out_valid && t < 100) begin @(negedge sysclk); t++; end
        check_value("bp_valid_wait", {63'd0, out_valid}, 64'd1);
        fork
`ifdef PERIOD_CHECK_EN
            send(32'sd0, 32'sd0, 1'b0, 32'sd0, 32'sd0, 10'd5, 20'h55555, 10'd5, 1'b0, 4);
`else
            send(32'sd0, 32'sd0, 1'b0, 32'sd0, 32'sd0, 10'd5, 20'h55555, 10'd5, 1'b0, 7);
`endif
        join_none
        for (int i = 0; i < 10; i++) begin
            @(negedge sysclk);
            check_value("bp_hold", {31'd0, out_valid, in_ready, out_escaped, out_depth, out_tag},
                        {31'd0, 1'b1, 1'b0, 1'b1, 10'd3, 20'haaaaa});
        end
        @(posedge sysclk); #2; out_ready = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        check_value("release_rdy", {62'd0, in_ready, out_valid}, 64'd2);
        drain();

        // Reset during ITER at depth 7
        send(-TWO, 32'sd0, 1'b0, 32'sd0, 32'sd0, 10'd100, 20'h77777, 10'd100, 1'b0, 102);
        repeat (7) @(posedge sysclk);
        #3;
        reset_n = 1'b0;
        #1;
        check_value("abort_outs", {32'd0, in_ready, out_valid, out_escaped, out_depth, out_tag},
                    {32'd0, 1'b1, 1'b0, 1'b0, 10'd0, 20'd0});
        sb.delete();
        @(negedge sysclk);
        reset_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge sysclk);
            if (out_valid) stale++;
        end
        check_value("no_stale_valid", 64'(stale), 64'd0);
        check_value("post_rst_ready", {63'd0, in_ready}, 64'd1);

        // Random pixels with random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 10; i++) send_rand(20'h80000 + 20'(i));
        t = 0;
        while (sb.size() != 0 && t < 3000) begin @(negedge sysclk); t++; end
        rand_bp = 1'b0;
        @(posedge sysclk); #3; out_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
